// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: one fetch per start, memory handshake, flush/drain, fault reporting.
// Latency: start to done is 3 cycles minimum (REQ, WAIT, DONE), plus any ready/rvalid stall cycles.
// Backpressure: request held stable until i_mem_ready; a flushed in-flight response is drained, not dropped.
module instr_fetch_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  i_start,
  input  logic                  i_flush,
  input  logic [ADDR_WIDTH-1:0] i_pc,
  output logic                  o_mem_req,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  input  logic                  i_mem_ready,
  input  logic                  i_mem_rvalid,
  input  logic                  i_mem_err,
  input  logic [DATA_WIDTH-1:0] i_mem_rdata,
  output logic [DATA_WIDTH-1:0] o_instr,
  output logic                  o_instr_we,
  output logic                  o_old_pc_we,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_fault,
  output logic                  o_misaligned
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic                  mis_q;
  logic                  fault_q;

  // decisions made by the next-state logic
  logic                  capture_addr;
  logic                  load_instr;
  logic                  mis_d;
  logic                  fault_d;
  logic                  pc_aligned;

  // word-aligned fetch addresses only; the two low bits must be zero
  assign pc_aligned = (i_pc[1:0] == 2'b00);

  // State register; reset may land in any state, including mid-fetch
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection plus capture/load/pulse decisions
  always_comb begin
    state_d      = state_q;
    capture_addr = 1'b0;
    load_instr   = 1'b0;
    mis_d        = 1'b0;
    fault_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        // flush wins over start; a misaligned start is refused with a pulse
        if (i_start && !i_flush) begin
          if (pc_aligned) begin
            capture_addr = 1'b1;
            state_d      = S_REQ;
          end else begin
            mis_d = 1'b1;
          end
        end
      end
      S_REQ: begin
        // once accepted, memory owes a response, so a flush must drain it
        if (i_mem_ready) begin
          state_d = i_flush ? S_DRAIN : S_WAIT;
        end else if (i_flush) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (i_mem_rvalid) begin
          if (i_flush) begin
            state_d = S_IDLE;
          end else if (i_mem_err) begin
            fault_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            load_instr = 1'b1;
            state_d    = S_DONE;
          end
        end else if (i_flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // swallow the outstanding response whatever its data or error flag
        if (i_mem_rvalid) begin
          state_d = S_IDLE;
        end
      end
      S_DONE: begin
        // write enables are already committed; flush has no effect here
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Fetch address register, loaded only on an accepted aligned start
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      addr_q <= '0;
    end else if (capture_addr) begin
      addr_q <= i_pc;
    end
  end

  // Instruction data register, loaded only on a clean response in WAIT
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      instr_q <= '0;
    end else if (load_instr) begin
      instr_q <= i_mem_rdata;
    end
  end

  // One-cycle status pulses for refused starts and error responses
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      mis_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      mis_q   <= mis_d;
      fault_q <= fault_d;
    end
  end

  // Outputs decoded from registered state so they never glitch on inputs
  always_comb begin
    o_mem_req    = (state_q == S_REQ);
    o_mem_addr   = addr_q;
    o_instr      = instr_q;
    o_instr_we   = (state_q == S_DONE);
    o_old_pc_we  = (state_q == S_DONE);
    o_done       = (state_q == S_DONE);
    o_busy       = (state_q != S_IDLE);
    o_fault      = fault_q;
    o_misaligned = mis_q;
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: directed scenarios plus randomized fetch transactions.
// Expected outputs come from a transaction-level timeline model (cycle offsets per fetch).
// Inputs are driven 1 time unit after posedge; outputs are sampled on negedge.
module tb_instr_fetch_ctrl;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk;
  logic          arstn;
  logic          i_start;
  logic          i_flush;
  logic [AW-1:0] i_pc;
  logic          o_mem_req;
  logic [AW-1:0] o_mem_addr;
  logic          i_mem_ready;
  logic          i_mem_rvalid;
  logic          i_mem_err;
  logic [DW-1:0] i_mem_rdata;
  logic [DW-1:0] o_instr;
  logic          o_instr_we;
  logic          o_old_pc_we;
  logic          o_busy;
  logic          o_done;
  logic          o_fault;
  logic          o_misaligned;

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] model_instr;

  instr_fetch_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .arstn        (arstn),
    .i_start      (i_start),
    .i_flush      (i_flush),
    .i_pc         (i_pc),
    .o_mem_req    (o_mem_req),
    .o_mem_addr   (o_mem_addr),
    .i_mem_ready  (i_mem_ready),
    .i_mem_rvalid (i_mem_rvalid),
    .i_mem_err    (i_mem_err),
    .i_mem_rdata  (i_mem_rdata),
    .o_instr      (o_instr),
    .o_instr_we   (o_instr_we),
    .o_old_pc_we  (o_old_pc_we),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_fault      (o_fault),
    .o_misaligned (o_misaligned)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // status bits: {req, busy, done, instr_we, old_pc_we, fault, misaligned}
  function automatic logic [6:0] status();
    return {o_mem_req, o_busy, o_done, o_instr_we, o_old_pc_we, o_fault, o_misaligned};
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet_inputs();
    i_start      = 1'b0;
    i_flush      = 1'b0;
    i_pc         = '0;
    i_mem_ready  = 1'b0;
    i_mem_rvalid = 1'b0;
    i_mem_err    = 1'b0;
    i_mem_rdata  = '0;
  endtask

  // One fetch transaction. Cycle 0 is the IDLE cycle carrying start; ready arrives
  // rd cycles into REQ, rvalid vd cycles into WAIT; f>=1 flushes in that cycle.
  // Precondition: called at posedge+1 with the DUT idle.
  task automatic run_fetch(input string tag, input logic [AW-1:0] pc, input int rd,
                           input int vd, input bit err, input int f, input logic [DW-1:0] data);
    int   ready_c;
    int   rvalid_c;
    int   end_c;
    int   busy_end;
    int   req_end;
    bit   flushed;
    bit   ok;
    logic e_req, e_busy, e_done, e_fault;
    logic [6:0] exp_st;
    logic [6:0] act_st;
    logic [DW-1:0] exp_i;
    ready_c  = 1 + rd;
    rvalid_c = 2 + rd + vd;
    end_c    = 3 + rd + vd;
    flushed  = (f >= 1) && (f <= rvalid_c);
    ok       = !flushed && !err;
    if (flushed) busy_end = (f < ready_c) ? f : rvalid_c;
    else         busy_end = err ? rvalid_c : end_c;
    req_end  = (ready_c < busy_end) ? ready_c : busy_end;
    for (int c = 0; c <= end_c; c++) begin
      i_flush     = (c == f);
      i_mem_ready = (c == ready_c);
      i_mem_rdata = $urandom;
      i_mem_err   = 1'($urandom);
      if (c == 0) begin
        i_start = 1'b1;
        i_pc    = pc;
      end else if (c <= busy_end) begin
        i_start = 1'($urandom);
        i_pc    = $urandom;
      end else begin
        i_start = 1'b0;
        i_pc    = $urandom;
      end
      if (c == rvalid_c) begin
        i_mem_rvalid = 1'b1;
        i_mem_err    = err;
        i_mem_rdata  = data;
      end else if ((c >= 1 && c <= rd) || c == end_c) begin
        i_mem_rvalid = 1'($urandom);
      end else begin
        i_mem_rvalid = 1'b0;
      end
      @(negedge clk);
      e_req   = (c >= 1) && (c <= req_end);
      e_busy  = (c >= 1) && (c <= busy_end);
      e_done  = ok && (c == end_c);
      e_fault = !flushed && err && (c == end_c);
      exp_st  = {e_req, e_busy, e_done, e_done, e_done, e_fault, 1'b0};
      act_st  = status();
      total++;
      if (act_st !== exp_st) begin
        bad++;
        $display("FAIL %s status c=%0d got=%b want=%b", tag, c, act_st, exp_st);
      end
      if (e_req) begin
        total++;
        if (o_mem_addr !== pc) begin
          bad++;
          $display("FAIL %s mem_addr c=%0d got=%h want=%h", tag, c, o_mem_addr, pc);
        end
      end
      exp_i = (ok && c >= end_c) ? data : model_instr;
      total++;
      if (o_instr !== exp_i) begin
        bad++;
        $display("FAIL %s instr c=%0d got=%h want=%h", tag, c, o_instr, exp_i);
      end
      next_cycle();
    end
    if (ok) model_instr = data;
    quiet_inputs();
  endtask

  // Idle cycles with memory noise and flush-qualified starts: nothing may happen
  task automatic test_idle_noise(input int n);
    logic [6:0] act_st;
    for (int c = 0; c < n; c++) begin
      i_start      = 1'($urandom);
      i_flush      = i_start | 1'($urandom);
      i_pc         = $urandom;
      i_mem_ready  = 1'($urandom);
      i_mem_rvalid = 1'($urandom);
      i_mem_err    = 1'($urandom);
      i_mem_rdata  = $urandom;
      @(negedge clk);
      act_st = status();
      total++;
      if (act_st !== 7'b0 || o_instr !== model_instr) begin
        bad++;
        $display("FAIL idle_noise c=%0d status=%b instr=%h want status=0 instr=%h",
                 c, act_st, o_instr, model_instr);
      end
      next_cycle();
    end
    quiet_inputs();
  endtask

  task automatic test_reset();
    quiet_inputs();
    arstn = 1'b1;
    #2;
    arstn = 1'b0;
    model_instr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (status() !== 7'b0) begin
      bad++;
      $display("FAIL reset status got=%b want=0", status());
    end
    total++;
    if (o_instr !== '0 || o_mem_addr !== '0) begin
      bad++;
      $display("FAIL reset regs instr=%h addr=%h want 0", o_instr, o_mem_addr);
    end
    @(posedge clk);
    #1;
    arstn = 1'b1;
    // start in the very first cycle after release
    run_fetch("post_reset", 32'h0000_0040, 0, 0, 1'b0, -1, 32'h0000_0093);
  endtask

  task automatic test_basic();
    run_fetch("basic", 32'h0000_0100, 0, 0, 1'b0, -1, 32'h0000_0013);
  endtask

  task automatic test_ready_stall();
    run_fetch("ready_stall", 32'h0000_2000, 4, 0, 1'b0, -1, 32'h1234_5678);
    run_fetch("rvalid_stall", 32'h0000_2004, 1, 3, 1'b0, -1, 32'h0BAD_F00D);
  endtask

  task automatic test_misaligned();
    logic [AW-1:0] pc;
    for (int k = 1; k < 4; k++) begin
      pc = 32'h0000_0100 | AW'(k);
      i_start = 1'b1;
      i_pc    = pc;
      @(negedge clk);
      next_cycle();
      quiet_inputs();
      @(negedge clk);
      total++;
      if (status() !== 7'b0000001) begin
        bad++;
        $display("FAIL misaligned pulse pc=%h got=%b want=0000001", pc, status());
      end
      next_cycle();
      @(negedge clk);
      total++;
      if (status() !== 7'b0) begin
        bad++;
        $display("FAIL misaligned end pc=%h got=%b want=0", pc, status());
      end
      next_cycle();
    end
    // misaligned start under flush is overridden entirely
    i_start = 1'b1;
    i_flush = 1'b1;
    i_pc    = 32'h0000_0102;
    next_cycle();
    quiet_inputs();
    @(negedge clk);
    total++;
    if (status() !== 7'b0) begin
      bad++;
      $display("FAIL misaligned_flush got=%b want=0", status());
    end
    next_cycle();
  endtask

  task automatic test_flush();
    run_fetch("flush_wait", 32'h0000_0300, 0, 2, 1'b0, 2, 32'hDEAD_BEEF);
    run_fetch("flush_req", 32'h0000_0304, 3, 1, 1'b0, 2, 32'h1111_2222);
    run_fetch("flush_accept", 32'h0000_0308, 2, 2, 1'b0, 3, 32'h3333_4444);
    run_fetch("flush_rvalid", 32'h0000_030C, 0, 1, 1'b0, 3, 32'h5555_6666);
    run_fetch("flush_done", 32'h0000_0310, 0, 0, 1'b0, 3, 32'h7777_8888);
  endtask

  task automatic test_error();
    run_fetch("error", 32'h0000_0400, 1, 1, 1'b1, -1, 32'hCAFE_0001);
    run_fetch("after_error", 32'h0000_0404, 0, 0, 1'b0, -1, 32'h0000_0517);
  endtask

  task automatic test_reset_midfetch();
    i_start = 1'b1;
    i_pc    = 32'h0000_0200;
    next_cycle();
    i_start     = 1'b0;
    i_mem_ready = 1'b1;
    next_cycle();
    i_mem_ready = 1'b0;
    #2;
    total++;
    if (o_busy !== 1'b1) begin
      bad++;
      $display("FAIL midfetch pre busy got=%b want=1", o_busy);
    end
    arstn = 1'b0;
    #1;
    model_instr = '0;
    total++;
    if (status() !== 7'b0 || o_instr !== '0 || o_mem_addr !== '0) begin
      bad++;
      $display("FAIL midfetch async status=%b instr=%h addr=%h want all 0",
               status(), o_instr, o_mem_addr);
    end
    i_mem_rvalid = 1'b1;
    i_mem_rdata  = 32'hFEED_FACE;
    next_cycle();
    arstn = 1'b1;
    @(negedge clk);
    next_cycle();
    i_mem_rvalid = 1'b0;
    @(negedge clk);
    total++;
    if (status() !== 7'b0 || o_instr !== '0) begin
      bad++;
      $display("FAIL midfetch late_rvalid status=%b instr=%h want 0", status(), o_instr);
    end
    next_cycle();
    run_fetch("after_midreset", 32'h0000_0208, 0, 0, 1'b0, -1, 32'h0000_A0B3);
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 4; k++) begin
      run_fetch("back_to_back", AW'(32'h0000_1000 + 4 * k), 0, 0, 1'b0, -1, $urandom);
    end
  endtask

  task automatic test_random();
    int rd;
    int vd;
    int f;
    bit err;
    for (int k = 0; k < 200; k++) begin
      rd  = $urandom_range(0, 5);
      vd  = $urandom_range(0, 5);
      err = ($urandom_range(0, 4) == 0);
      f   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3 + rd + vd)) : -1;
      run_fetch("random", $urandom & ~32'h3, rd, vd, err, f, $urandom);
      if ($urandom_range(0, 3) == 0) test_idle_noise($urandom_range(1, 3));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ready_stall();
    test_misaligned();
    test_flush();
    test_error();
    test_reset_midfetch();
    test_idle_noise(6);
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
INSTR_FETCH_CTRL -- requirements
Module: instr_fetch_ctrl

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the instruction/read-data width.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL set the PC/memory address width.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on posedge clk.
REQ-004 arstn  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 i_start  input  1  SHALL request one instruction fetch from the control FSM.
REQ-006 i_flush  input  1  SHALL abort any fetch in flight.
REQ-007 i_pc  input  ADDR_WIDTH  SHALL give the fetch address, sampled with i_start.
REQ-008 o_mem_req  output  1  SHALL be the memory request valid.
REQ-009 o_mem_addr  output  ADDR_WIDTH  SHALL be the request address.
REQ-010 i_mem_ready  input  1  SHALL accept the request when high with o_mem_req.
REQ-011 i_mem_rvalid  input  1  SHALL qualify returned read data.
REQ-012 i_mem_err  input  1  SHALL flag an erroneous response, valid with i_mem_rvalid.
REQ-013 i_mem_rdata  input  DATA_WIDTH  SHALL carry the returned instruction word.
REQ-014 o_instr  output  DATA_WIDTH  SHALL drive the instruction register write data.
REQ-015 o_instr_we  output  1  SHALL drive the instruction register write enable.
REQ-016 o_old_pc_we  output  1  SHALL drive the old-PC register write enable.
REQ-017 o_busy / o_done / o_fault / o_misaligned  output  1 each  SHALL report status.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, DRAIN, DONE.
REQ-019 IDLE: i_start=1, i_flush=0, i_pc[1:0]==0 SHALL capture i_pc into the address register and move to REQ.
REQ-020 IDLE: i_start=1 with i_pc[1:0]!=0 SHALL stay IDLE, issue no request, pulse o_misaligned for exactly one cycle next cycle.
REQ-021 i_start SHALL be ignored outside IDLE; i_flush=1 in IDLE SHALL override i_start.
REQ-022 REQ: o_mem_req=1, o_mem_addr=captured address, both stable until i_mem_ready=1; on i_mem_ready=1 move to WAIT.
REQ-023 o_mem_req SHALL be 0 in every state except REQ.
REQ-024 WAIT: i_mem_rvalid=1, i_mem_err=0 SHALL register i_mem_rdata into o_instr and move to DONE.
REQ-025 WAIT: i_mem_rvalid=1, i_mem_err=1 SHALL pulse o_fault one cycle next cycle, leave o_instr unchanged, return to IDLE.
REQ-026 DONE: o_instr_we=1, o_old_pc_we=1, o_done=1 for exactly one cycle, then IDLE.
REQ-027 o_busy SHALL be 1 in REQ, WAIT, DRAIN, DONE and 0 in IDLE.
REQ-028 i_flush in REQ without i_mem_ready SHALL drop the request and go IDLE next cycle.
REQ-029 i_flush in REQ coincident with i_mem_ready (request accepted) SHALL go to DRAIN.
REQ-030 i_flush in WAIT without i_mem_rvalid SHALL go to DRAIN; with i_mem_rvalid the response SHALL be discarded and go IDLE.
REQ-031 DRAIN: wait for i_mem_rvalid, discard data and error, then IDLE; no write enables, o_done or o_fault.
REQ-032 i_flush in DONE SHALL be ignored; write enables still pulse.
REQ-033 Minimum latency i_start to o_done SHALL be 3 cycles (ready in REQ's first cycle, rvalid in WAIT's first cycle).
REQ-034 i_mem_rvalid outside WAIT/DRAIN SHALL be ignored.

Reset
REQ-035 arstn=0 SHALL asynchronously force IDLE, address and o_instr to 0, all 1-bit outputs to 0, at any state including mid-fetch.
REQ-036 After arstn deasserts, the first posedge SHALL be able to accept i_start.

Verification
REQ-037 i_pc=0x0000_0100, start, ready and rvalid immediate, rdata=0x0000_0013 -> o_mem_addr=0x100 in REQ, o_instr=0x13, o_instr_we/o_old_pc_we/o_done one cycle at cycle 3.
REQ-038 start, ready held low 4 cycles -> o_mem_req and o_mem_addr stable all 4 cycles, done at cycle 7.
REQ-039 i_pc=0x0000_0102, start -> o_misaligned one-cycle pulse, o_mem_req never high, o_busy stays 0.
REQ-040 flush in WAIT, rvalid 2 cycles later with rdata=0xDEAD_BEEF -> DRAIN then IDLE, o_instr unchanged, no write enable.
REQ-041 rvalid with i_mem_err=1 -> o_fault one cycle, no write enable; subsequent start fetches normally.
REQ-042 arstn low during WAIT -> outputs 0 immediately (before next edge), state IDLE, late rvalid ignored.
